// File: rtl/dma_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dma_mem_bridge
// Purpose  : Bridges the DMA engine's read/write burst channels onto a shared
//            single-port, word-addressed synchronous SRAM. One burst is active
//            at a time. Read and write requests are arbitrated round-robin.
//            Read beats return through a 2-entry skid buffer. No strobe is
//            issued while the CPU owns the port (mem_gnt low).
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            rd_req_* / rd_*           - read burst request and beat return
//            wr_req_* / wr_*           - write burst request and beat intake
//            mem_*                     - SRAM port (read data one cycle late)
//            err                       - sticky wr_last / length mismatch flag
// Revision : 1.0 - initial release
// ============================================================================
module dma_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [4:0]            rd_req_len,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [4:0]            wr_req_len,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_gnt,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_wr_q, last_wr_d;   // 1: last served was a write
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [4:0]              len_q, len_d;
  logic [4:0]              beat_cnt_q, beat_cnt_d;
  logic [5:0]              issue_cnt_q, issue_cnt_d; // runs to len+1, needs 6 bits
  logic                    inflight_q;
  logic                    err_q;

  // Skid buffer: two entries, head/tail pointers and occupancy
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic                    head_q, tail_q;
  logic [1:0]              buf_cnt_q;

  logic                    w_idle, w_grant_rd, w_grant_wr;
  logic                    w_pop, w_issue, w_wacc, w_wr_end;
  logic [2:0]              w_occ;

  assign w_idle     = (state_q == S_IDLE) && !rst;
  // Both pending: serve the type opposite to the last one served
  assign w_grant_rd = w_idle && rd_req_valid && (!wr_req_valid || last_wr_q);
  assign w_grant_wr = w_idle && wr_req_valid && !w_grant_rd;

  assign rd_valid   = (buf_cnt_q != 2'd0);
  assign w_pop      = rd_valid && rd_ready;

  // Occupancy once this cycle settles; an issue now lands in the buffer next
  // cycle, so the buffer plus the in-flight beat must leave room for it.
  assign w_occ      = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_issue    = !rst && (state_q == S_RD) && mem_gnt &&
                      (issue_cnt_q <= {1'b0, len_q}) && (w_occ < 3'd2);

  assign wr_ready   = !rst && (state_q == S_WR) && mem_gnt;
  assign w_wacc     = wr_ready && wr_valid;
  assign w_wr_end   = (beat_cnt_q == len_q);

  assign rd_req_ready = w_grant_rd;
  assign wr_req_ready = w_grant_wr;
  assign rd_rdata     = rd_valid ? buf_q[head_q] : '0;
  assign rd_last      = rd_valid && (beat_cnt_q == len_q);
  assign mem_ren      = w_issue;
  assign mem_wen      = w_wacc;
  assign mem_wdata    = w_wacc ? wr_data : '0;
  assign err          = err_q;

  // Offsets are word multiples; the sum wraps modulo 2^ADDR_WIDTH
  always_comb begin
    mem_addr = '0;
    if (w_issue) begin
      mem_addr = base_q + {{(ADDR_WIDTH-8){1'b0}}, issue_cnt_q, 2'b00};
    end else if (w_wacc) begin
      mem_addr = base_q + {{(ADDR_WIDTH-7){1'b0}}, beat_cnt_q, 2'b00};
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    base_d      = base_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    issue_cnt_d = issue_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant_rd) begin
          base_d      = rd_req_addr & C_ALIGN_MASK;
          len_d       = rd_req_len;
          beat_cnt_d  = '0;
          issue_cnt_d = '0;
          last_wr_d   = 1'b0;
          state_d     = S_RD;
        end else if (w_grant_wr) begin
          base_d      = wr_req_addr & C_ALIGN_MASK;
          len_d       = wr_req_len;
          beat_cnt_d  = '0;
          issue_cnt_d = '0;
          last_wr_d   = 1'b1;
          state_d     = S_WR;
        end
      end
      S_RD: begin
        if (w_issue) begin
          issue_cnt_d = issue_cnt_q + 6'd1;
        end
        if (w_pop) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (beat_cnt_q == len_q) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WR: begin
        if (w_wacc) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (w_wr_end) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_wr_q   <= 1'b1;
      base_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      buf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      base_q      <= base_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= w_issue;
      // Length is governed by len; a misplaced wr_last only flags the error
      if (w_wacc && (wr_last != w_wr_end)) begin
        err_q <= 1'b1;
      end
      if (inflight_q) begin
        tail_q <= ~tail_q;
      end
      if (w_pop) begin
        head_q <= ~head_q;
      end
      buf_cnt_q <= buf_cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
    end
  end

  // Buffer storage needs no reset; the occupancy count qualifies it
  always_ff @(posedge clk) begin
    if (!rst && inflight_q) begin
      buf_q[tail_q] <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_mem_bridge
// Purpose  : Scoreboard bench for dma_mem_bridge. Stimulus tasks push the
//            expected read beats and memory strobes into queues; a monitor
//            pops and compares whenever the DUT presents them. A behavioural
//            SRAM returns {16'hCAFE, addr[15:0]} for never-written words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_req_addr, wr_req_addr;
  logic [4:0]  rd_req_len, wr_req_len;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_rdata;
  logic        rd_valid, rd_last, rd_ready;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_data;
  logic        wr_valid, wr_last, wr_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen, mem_gnt, err;

  always #5 clk = ~clk;

  dma_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_rdata(rd_rdata), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_ready(rd_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_gnt(mem_gnt),
    .err(err)
  );

  // Behavioural SRAM
  logic [31:0] wmem  [4096];
  bit          wflag [4096];
  always @(posedge clk) begin
    if (mem_wen) begin
      wmem[mem_addr[13:2]]  <= mem_wdata;
      wflag[mem_addr[13:2]] <= 1'b1;
    end
    if (mem_ren) begin
      mem_rdata <= wflag[mem_addr[13:2]] ? wmem[mem_addr[13:2]]
                                         : {16'hCAFE, mem_addr[15:0]};
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] rd_exp  [$];   // {last, data}
  logic [31:0] ren_exp [$];   // expected mem_addr on mem_ren
  logic [63:0] wen_exp [$];   // expected {mem_addr, mem_wdata} on mem_wen
  int          grant_seen [$]; // 0 = read, 1 = write
  int          beats_seen = 0;
  int          ren_total  = 0;
  int          ren_streak = 0;
  bit          prev_ren   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req_valid && rd_req_ready) grant_seen.push_back(0);
      if (wr_req_valid && wr_req_ready) grant_seen.push_back(1);
      if (rd_valid) chk("buf_count_le2", 64'(dut.buf_cnt_q <= 2'd2), 64'd1);
      if (rd_valid && rd_ready) begin
        beats_seen++;
        if (rd_exp.size() == 0) timeout("rd_beat_unexpected");
        else chk("rd_beat", {31'd0, rd_last, rd_rdata}, {31'd0, rd_exp.pop_front()});
      end
      if (mem_ren || mem_wen) chk("ren_wen_exclusive", 64'(mem_ren && mem_wen), 64'd0);
      if (mem_ren) begin
        ren_total++;
        ren_streak = prev_ren ? ren_streak + 1 : 1;
        if (ren_exp.size() == 0) timeout("mem_ren_unexpected");
        else chk("mem_ren_addr", {32'd0, mem_addr}, {32'd0, ren_exp.pop_front()});
      end
      if (mem_wen) begin
        if (wen_exp.size() == 0) timeout("mem_wen_unexpected");
        else chk("mem_wen_addr_data", {mem_addr, mem_wdata}, wen_exp.pop_front());
      end
    end
    prev_ren = mem_ren;
  end

  task automatic rd_burst(input logic [31:0] a, input logic [4:0] l);
    for (int k = 0; k <= int'(l); k++) begin
      logic [31:0] ad;
      ad = a + 32'(4 * k);
      ren_exp.push_back(ad);
      rd_exp.push_back({(k == int'(l)), 16'hCAFE, ad[15:0]});
    end
    rd_req_addr  = a;
    rd_req_len   = l;
    rd_req_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (rd_req_ready) break;
      if (t > 300) begin timeout("rd_req_accept"); break; end
    end
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
  endtask

  // bad_idx: beat on which wr_last is wrongly raised (the true last is then
  // left low); -1 for a well-formed burst
  task automatic wr_burst(input logic [31:0] a, input logic [4:0] l,
                          input logic [31:0] d0, input int bad_idx);
    wr_req_addr  = a;
    wr_req_len   = l;
    wr_req_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (wr_req_ready) break;
      if (t > 300) begin timeout("wr_req_accept"); break; end
    end
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
    for (int k = 0; k <= int'(l); k++) begin
      wr_data  = d0 + 32'(k);
      wr_last  = (bad_idx < 0) ? (k == int'(l)) : (k == bad_idx);
      wr_valid = 1'b1;
      wen_exp.push_back({a + 32'(4 * k), d0 + 32'(k)});
      for (int t = 0; ; t++) begin
        @(negedge clk);
        if (wr_ready) break;
        if (t > 100) begin timeout("wr_beat_accept"); break; end
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic wait_rd_done();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (rd_exp.size() == 0) break;
      if (t > 300) begin timeout("rd_drain"); break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctl"}, {56'd0, rd_req_ready, rd_valid, rd_last, wr_req_ready,
                         wr_ready, mem_ren, mem_wen, err}, 64'd0);
    chk({name, "_rdata"}, {32'd0, rd_rdata}, 64'd0);
    chk({name, "_maddr"}, {32'd0, mem_addr}, 64'd0);
    chk({name, "_mwdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  initial begin
    int s;
    rst = 1'b1;
    rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0; rd_ready = 1'b1;
    wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
    wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0; mem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;

    // Arbitration: simultaneous requests from reset, then again
    grant_seen.delete();
    fork
      rd_burst(32'h0000_1100, 5'd1);
      wr_burst(32'h0000_3000, 5'd1, 32'h0000_00C0, -1);
    join
    wait_rd_done();
    fork
      rd_burst(32'h0000_1200, 5'd0);
      wr_burst(32'h0000_3100, 5'd0, 32'h0000_00C2, -1);
    join
    wait_rd_done();
    chk("grant_count", 64'(grant_seen.size()), 64'd4);
    chk("grant_order", {60'd0, 4'(grant_seen[0]), 4'(grant_seen[1]),
                        4'(grant_seen[2]), 4'(grant_seen[3])} & 64'hFFFF, 64'h0101);

    // Read burst at 0x1000, len 7, full throughput
    s = beats_seen;
    ren_streak = 0;
    begin
      int r0;
      r0 = ren_total;
      rd_burst(32'h0000_1000, 5'd7);
      wait_rd_done();
      chk("rd1_beats", 64'(beats_seen - s), 64'd8);
      chk("rd1_ren_count", 64'(ren_total - r0), 64'd8);
      chk("rd1_ren_consecutive", 64'(ren_streak), 64'd8);
    end

    // Read with rd_ready toggling and a 3-cycle grant loss
    s = beats_seen;
    fork
      rd_burst(32'h0000_1000, 5'd7);
      begin
        repeat (4) @(posedge clk);
        #1 mem_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_gnt = 1'b1;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(posedge clk); #1 rd_ready = ~rd_ready;
        end
        rd_ready = 1'b1;
      end
    join
    wait_rd_done();
    chk("rd2_beats", 64'(beats_seen - s), 64'd8);

    // Write burst at 0x2000, len 7
    wr_burst(32'h0000_2000, 5'd7, 32'h0000_00A0, -1);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++)
      chk("wr1_mem", {32'd0, wmem[12'h800 + 12'(k)]}, 64'h0000_00A0 + 64'(k));
    chk("wr1_err", 64'(err), 64'd0);

    // Write with wr_last on beat 4 of len 7
    wr_burst(32'h0000_2000, 5'd7, 32'h0000_00B0, 3);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++)
      chk("wr2_mem", {32'd0, wmem[12'h800 + 12'(k)]}, 64'h0000_00B0 + 64'(k));
    chk("wr2_err_set", 64'(err), 64'd1);
    repeat (3) @(posedge clk); #1;
    chk("wr2_err_sticky", 64'(err), 64'd1);

    // Reset after three delivered beats of a read burst
    s = beats_seen;
    fork
      rd_burst(32'h0000_1000, 5'd7);
      begin
        for (int t = 0; ; t++) begin
          @(posedge clk); #1;
          if (beats_seen - s >= 3) break;
          if (t > 100) begin timeout("rd3_three_beats"); break; end
        end
      end
    join
    rst = 1'b1;
    rd_exp.delete();
    ren_exp.delete();
    @(negedge clk);
    chk("rst_strobes", {62'd0, mem_ren, mem_wen}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    @(posedge clk); #1;
    s = beats_seen;
    rd_burst(32'h0000_1040, 5'd0);
    wait_rd_done();
    chk("rd4_single_beat", 64'(beats_seen - s), 64'd1);

    repeat (4) @(posedge clk);
    chk("rd_exp_left", 64'(rd_exp.size()), 64'd0);
    chk("ren_exp_left", 64'(ren_exp.size()), 64'd0);
    chk("wen_exp_left", 64'(wen_exp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/dma_mem_bridge.md
# dma_mem_bridge

Burst-to-SRAM bridge between the DMA engine's memory-side burst channels and a shared single-port, word-addressed synchronous memory. It accepts one read or write burst at a time, sequences the per-beat memory accesses, and returns read beats through a 2-entry skid buffer. Bursts are arbitrated round-robin, and access stalls are honoured while the CPU owns the port (`mem_gnt` low).

## Interface
- `ADDR_WIDTH`, 32: byte-address width.
- `DATA_WIDTH`, 32: beat width. Fixed at 32; other values are unsupported.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rd_req_addr`  in  32  burst start byte address.
- `rd_req_len`  in  5  beats minus 1.
- `rd_req_valid`  in  1  read request.
- `rd_req_ready`  out  1  read request accepted.
- `rd_rdata`  out  32  read beat data.
- `rd_valid`  out  1  read beat valid.
- `rd_last`  out  1  final beat of the burst.
- `rd_ready`  in  1  engine accepts the beat.
- `wr_req_addr`, `wr_req_len`, `wr_req_valid`  in  32/5/1  write request.
- `wr_req_ready`  out  1  write request accepted.
- `wr_data`  in  32  write beat.
- `wr_valid`  in  1  write beat valid.
- `wr_last`  in  1  engine's last-beat flag.
- `wr_ready`  out  1  write beat accepted.
- `mem_addr`  out  32  word-aligned address; bits [1:0] are always 0.
- `mem_ren`  out  1  read strobe.
- `mem_wen`  out  1  write strobe.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid the cycle after `mem_ren`.
- `mem_gnt`  in  1  port granted; no strobe is issued while low.
- `err`  out  1  sticky `wr_last` mismatch flag.

## Operation
- States: IDLE, RD, WR. Reset state is IDLE.
- **IDLE arbitration.**
  - Only one request pending: grant it.
  - Both pending: grant the opposite of the last served type. `last_served` resets to "write", so reads win first.
  - Grant cycle: the matching `*_req_ready` is 1 (combinational, IDLE only). Address and length are latched with bits [1:0] cleared. `beat_cnt` and `issue_cnt` are set to 0. Next state is RD or WR.
- **RD state.**
  - Issue condition: `mem_gnt`, `issue_cnt <= len`, and (`buf_count` + `inflight` − `pop`) < 2, where `pop` = `rd_valid` && `rd_ready`.
  - On issue: `mem_ren`=1, `mem_addr` = base + 4·`issue_cnt`, `inflight` is set for the next cycle.
  - The cycle after an issue, `mem_rdata` is pushed into the buffer.
  - `rd_valid` = `buf_count` != 0. `rd_rdata` is the buffer head. `rd_last` = `rd_valid` && (`beat_cnt` == len).
  - `beat_cnt` increments on each pop. Pop of the last beat returns to IDLE.
- **WR state.**
  - `wr_ready` = `mem_gnt`.
  - On `wr_valid` && `wr_ready`: `mem_wen`=1, `mem_addr` = base + 4·`beat_cnt`, `mem_wdata` = `wr_data`, `beat_cnt`++.
  - The burst ends on the beat where `beat_cnt` == len; return to IDLE.
  - If `wr_last` != (`beat_cnt` == len) on an accepted beat, `err` is set. The burst length is still governed by len.
- Address arithmetic is 32-bit modulo; increments wrap past 0xFFFFFFFC without error.
- `mem_ren` and `mem_wen` are never both 1.

## Timing
- Reset values: all outputs 0; `buf_count`, `inflight`, counters and `err` are 0.
- `rst` mid-burst:
  - Return to IDLE next cycle and clear the buffer and `inflight`.
  - Data returning for a pre-reset `mem_ren` is discarded.
  - Strobes are forced to 0 during the `rst` cycle.
- Read latency: `rd_req_ready` at cycle T, first `mem_ren` at T+1 (if granted), first `rd_valid` at T+3.
- Sustained throughput with `rd_ready`=1 and `mem_gnt`=1: 1 beat/cycle.
- Write: one beat per cycle while `wr_valid` && `mem_gnt`. The strobe is in the same cycle as the handshake.
- `mem_gnt` low mid-read: issuing stops; the in-flight beat is still captured; the buffer never exceeds 2 entries.
- `rd_ready` low: the buffer fills to 2 and issuing stops; no beat is lost or duplicated.
- `len`=0: single-beat burst, with `rd_last` asserted on the first beat.
- `*_req_ready` is never asserted outside IDLE.

## Test plan
- Read burst, addr 0x1000, len 7, `rd_ready`=1 → `mem_addr` 0x1000..0x101C on 8 consecutive cycles; 8 beats in order; `rd_last` on beat 8 only; back in IDLE.
- Read with `rd_ready` toggling 1/0 and `mem_gnt` low for 3 cycles mid-burst → 8 beats match memory contents; `buf_count` ≤ 2; no duplicates.
- Write burst, addr 0x2000, len 7, data 0xA0..0xA7 → memory 0x2000..0x201C holds 0xA0..0xA7; `err`=0.
- Simultaneous read and write requests from reset → read granted first; after it completes, write granted; then with both pending again → read next.
- Write with `wr_last` asserted on beat 4 of len 7 → `err`=1 and stays 1; 8 beats are written.
- `rst` asserted after 3 read beats delivered → all outputs 0 next cycle; a fresh len-0 read returns exactly one beat with `rd_last`=1.
